// File: rtl/wb16_pkg.sv
// Shared types for the 16-bit Wishbone arbiter.
// Cycle/burst type aliases and arbitration mode.
package wb16_pkg;

  typedef logic [2:0] cti_t;
  typedef logic [1:0] bte_t;

  typedef enum logic {
    RR    = 1'b0,
    FIXED = 1'b1
  } arb_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam cti_t CTI_CLASSIC = 3'b000;
  localparam cti_t CTI_INCR    = 3'b010;
  localparam cti_t CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb16_rr_pick.sv
// Rotating-priority picker: first request at or after ptr wins.
// ptr of zero gives plain lowest-index priority.
module wb16_rr_pick #(
  parameter int NM = 4,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= NM) s = s - NM;
    return PW'(s);
  endfunction

  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && req[wrap(ptr, i)]) begin
        found              = 1'b1;
        win[wrap(ptr, i)]  = 1'b1;
        win_idx            = wrap(ptr, i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/wb16_arbiter.sv
// N-master Wishbone arbiter with whole-cycle grants and
// a stall watchdog that faults a silent slave.
module wb16_arbiter
  import wb16_pkg::*;
#(
  parameter int        NM         = 4,
  parameter int        DATA_BYTES = 2,
  parameter int        ADDR_W     = 32,
  parameter int        TIMEOUT    = 255,
  parameter arb_mode_t MODE       = RR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NM-1:0]              s_cyc,
  input  logic [NM-1:0]              s_stb,
  input  logic [NM-1:0]              s_we,
  input  logic [NM*ADDR_W-1:0]       s_adr,
  input  logic [NM*8*DATA_BYTES-1:0] s_dat_ms,
  input  logic [NM*DATA_BYTES-1:0]   s_sel,
  input  logic [NM*3-1:0]            s_cti,
  input  logic [NM*2-1:0]            s_bte,
  output logic [NM-1:0]              s_ack,
  output logic [NM-1:0]              s_err,
  output logic [NM*8*DATA_BYTES-1:0] s_dat_sm,
  output logic                       m_cyc,
  output logic                       m_stb,
  output logic                       m_we,
  output logic [ADDR_W-1:0]          m_adr,
  output logic [8*DATA_BYTES-1:0]    m_dat_ms,
  output logic [DATA_BYTES-1:0]      m_sel,
  output cti_t                       m_cti,
  output bte_t                       m_bte,
  input  logic                       m_ack,
  input  logic                       m_err,
  input  logic [8*DATA_BYTES-1:0]    m_dat_sm,
  output logic [NM-1:0]              gnt
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int PW = $clog2(NM);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);

  arb_state_t    state, state_nx;
  logic [NM-1:0] gnt_nx;
  logic [PW-1:0] last_w, last_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [NM-1:0] pick_win;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic [PW-1:0] ptr;

  logic              cyc_g, stb_g, we_g;
  logic [ADDR_W-1:0] adr_g;
  logic [DW-1:0]     dat_g;
  logic [DATA_BYTES-1:0] sel_g;
  cti_t              cti_g;
  bte_t              bte_g;
  logic              stall, tmo;

  // FIXED always searches from master 0
  always_comb begin
    if (MODE == FIXED)
      ptr = '0;
    else if (last_w == PW'(NM - 1))
      ptr = '0;
    else
      ptr = last_w + 1'b1;
  end

  wb16_rr_pick #(
    .NM (NM),
    .PW (PW)
  ) u_pick (
    .req     (s_cyc),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    we_g  = 1'b0;
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    cti_g = '0;
    bte_g = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt[i]) begin
        cyc_g = s_cyc[i];
        stb_g = s_stb[i];
        we_g  = s_we[i];
        adr_g = s_adr[i*ADDR_W +: ADDR_W];
        dat_g = s_dat_ms[i*DW +: DW];
        sel_g = s_sel[i*DATA_BYTES +: DATA_BYTES];
        cti_g = s_cti[i*3 +: 3];
        bte_g = s_bte[i*2 +: 2];
      end
    end
  end

  assign stall = (state == OWNED) & cyc_g & stb_g
               & ~m_ack & ~m_err;
  assign tmo   = stall & (cnt == T_LAST);

  assign m_cyc    = cyc_g & ~tmo;
  assign m_stb    = stb_g & ~tmo;
  assign m_we     = we_g;
  assign m_adr    = adr_g;
  assign m_dat_ms = dat_g;
  assign m_sel    = sel_g;
  assign m_cti    = cti_g;
  assign m_bte    = bte_g;

  assign s_ack = gnt & {NM{m_ack}};
  assign s_err = gnt & {NM{m_err | tmo}};

  always_comb begin
    s_dat_sm = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt[i]) s_dat_sm[i*DW +: DW] = m_dat_sm;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last_w;
    cnt_nx   = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = OWNED;
          gnt_nx   = pick_win;
          last_nx  = pick_idx;
        end
      end
      OWNED: begin
        if (!cyc_g || tmo) begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end else if (stall) begin
          cnt_nx = (cnt == T_MAX) ? cnt : cnt + 1'b1;
        end else if (!(m_ack | m_err)) begin
          cnt_nx = cnt;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      last_w <= PW'(NM - 1);
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      last_w <= last_nx;
      cnt    <= cnt_nx;
    end
  end

endmodule

// File: doc/wb16_arbiter.md
WB16_ARBITER -- requirements
Module: wb16_arbiter

Interface
REQ-001 The module SHALL take parameter NM, default 4, number of Wishbone masters (legal range 2..8).
REQ-002 The module SHALL take parameter DATA_BYTES, default 2, data bus width in bytes.
REQ-003 The module SHALL take parameter ADDR_W, default 32, address width.
REQ-004 The module SHALL take parameter TIMEOUT, default 255, the number of stalled strobe cycles before the bus faults (legal range 1..65535).
REQ-005 The module SHALL take parameter MODE, default RR, the arbitration mode (RR round-robin, FIXED lowest-index-wins).
REQ-006 The module SHALL have these ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_cyc, s_stb, s_we  in  NM  per-master cycle, strobe and write.
- s_adr  in  NM*ADDR_W  per-master address, packed.
- s_dat_ms  in  NM*8*DATA_BYTES  per-master write data.
- s_sel  in  NM*DATA_BYTES  per-master byte selects.
- s_cti  in  NM*3  per-master cycle-type identifier.
- s_bte  in  NM*2  per-master burst-type extension.
- s_ack, s_err  out  NM  per-master acknowledge and error.
- s_dat_sm  out  NM*8*DATA_BYTES  per-master read data.
- m_cyc, m_stb, m_we, m_adr, m_dat_ms, m_sel, m_cti, m_bte  out  as for one master  downstream request.
- m_ack, m_err  in  1  downstream acknowledge and error.
- m_dat_sm  in  8*DATA_BYTES  downstream read data.
- gnt  out  NM  one-hot grant, or zero when idle.

Function
REQ-007 The FSM SHALL have two states, IDLE and OWNED.
REQ-008 In IDLE with any s_cyc high, the arbiter SHALL choose a winner, register gnt, and go to OWNED on the next edge; arbitration latency is 1 cycle.
REQ-009 In RR mode, the search SHALL start at index (last_winner+1) mod NM and wrap around; last_winner resets to NM-1, so master 0 wins first.
REQ-010 In FIXED mode, the lowest-index requesting master SHALL win.
REQ-011 In OWNED, the granted master's request signals SHALL be routed to the m_* outputs, and m_ack, m_err and m_dat_sm SHALL be routed to that master only.
REQ-012 All non-granted masters SHALL see s_ack=0, s_err=0 and s_dat_sm=0.
REQ-013 In IDLE, the m_* outputs SHALL all be zero.
REQ-014 The grant SHALL be held for the whole cycle, with no preemption, including Wishbone registered-feedback bursts (cti 001/010), regardless of other requests.
REQ-015 The arbiter SHALL release the grant when the granted s_cyc is sampled low; it then returns to IDLE, and a new arbitration occurs in the following cycle.
REQ-016 A master that deasserts s_cyc while not granted SHALL lose its pending request without side effects.
REQ-017 The stall counter SHALL increment each cycle in OWNED with m_stb=1 and m_ack=0 and m_err=0, and SHALL clear on ack, on err, or on leaving OWNED.
REQ-018 When the stall counter reaches TIMEOUT:
- s_err SHALL pulse for 1 cycle to the granted master;
- m_cyc and m_stb SHALL be forced low from that cycle;
- the FSM SHALL go to IDLE on the next edge.
REQ-019 The stall counter width SHALL be $clog2(TIMEOUT+1) and it SHALL saturate, never wrapping.
REQ-020 If m_ack and the timeout occur in the same cycle, ack SHALL win: s_ack=1, s_err=0, and the counter clears.
REQ-021 If all NM masters request simultaneously in RR mode, the grant SHALL visit each master exactly once per NM cycles-of-ownership.
REQ-022 The datapath muxes SHALL be combinational from gnt; there is no added data latency.

Reset
REQ-023 While rst_n is low, the block SHALL hold: state=IDLE, gnt=0, last_winner=NM-1, stall counter=0, all m_* outputs=0, all s_ack/s_err/s_dat_sm=0.
REQ-024 Reset asserted mid-cycle SHALL drop m_cyc immediately (asynchronously); no err is issued.

Structure
REQ-025 Package wb16_pkg SHALL hold the cti_t and bte_t typedefs, the arb_mode_t enum (RR, FIXED) and the CTI_CLASSIC/CTI_INCR/CTI_EOB constants.
REQ-026 Sub-module wb16_rr_pick SHALL be a combinational NM-wide request/pointer to one-hot winner picker shared by both modes.

Verification
REQ-027 Reset release with s_cyc=4'b0101 SHALL give gnt=0001 one cycle later; after master 0 drops cyc, gnt SHALL be 0100 two cycles later.
REQ-028 With all four masters requesting, each doing 1-beat cycles in RR mode, the grant order SHALL be 0,1,2,3,0; in FIXED mode, master 0 SHALL win every time while it requests.
REQ-029 Master 2 granted on a 4-beat incrementing burst (cti 010,010,010,111) with master 1 requesting SHALL keep all 4 acks routed to master 2, and master 1 SHALL be granted only after master 2's cyc falls.
REQ-030 With TIMEOUT=8 and a slave that never acks, s_err SHALL pulse on the 8th stalled cycle, m_cyc SHALL fall in the same cycle, and gnt SHALL be 0 on the next cycle.
REQ-031 With TIMEOUT=8 and m_ack arriving on exactly the 8th stalled cycle, the bench SHALL see s_ack=1 and s_err=0.
REQ-032 rst_n pulled low mid-burst SHALL drive m_cyc=0 and gnt=0 before the next clock edge; after release, master 0 SHALL win the first arbitration.
